// File: rtl/dual_frame_arbiter.sv
// Two-channel frame arbiter: whole frames are granted alternately onto one registered output stage.
// Optional frame-length watchdog is compiled in with `define ARB_TIMEOUT_EN.
module dual_frame_arbiter #(
    parameter int DATA_WIDTH    = 256,
    parameter int MAX_FRAME_LEN = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,

    input  logic                  S0_VALID,
    output logic                  S0_READY,
    input  logic [DATA_WIDTH-1:0] S0_DATA,
    input  logic                  S0_LAST,

    input  logic                  S1_VALID,
    output logic                  S1_READY,
    input  logic [DATA_WIDTH-1:0] S1_DATA,
    input  logic                  S1_LAST,

    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_LAST,
    output logic                  M_CH,

    output logic                  TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    if (MAX_FRAME_LEN < 2 || MAX_FRAME_LEN > 65535) begin : gBadFrameLen
        $error("dual_frame_arbiter: MAX_FRAME_LEN must be in 2..65535");
    end

    state_t                  state_q, state_d;
    logic                    lastGrant_q, lastGrant_d;
    logic                    mValid_q, mValid_d;
    logic [DATA_WIDTH-1:0]   mData_q, mData_d;
    logic                    mLast_q, mLast_d;
    logic                    mCh_q, mCh_d;
    logic                    timeoutErr_q, timeoutErr_d;

    logic                    slotFree;
    logic                    selValid;
    logic                    selLast;
    logic [DATA_WIDTH-1:0]   selData;
    logic                    selCh;
    logic                    accept;
    logic                    forceEnd;
    logic                    frameEnd;

    // The output slot can take a new beat when it is empty or being drained this cycle.
    assign slotFree = !mValid_q || M_READY;

    always_comb begin
        selValid = 1'b0;
        selLast  = 1'b0;
        selData  = S0_DATA;
        selCh    = 1'b0;
        case (state_q)
            GRANT0: begin
                selValid = S0_VALID;
                selLast  = S0_LAST;
                selData  = S0_DATA;
                selCh    = 1'b0;
            end
            GRANT1: begin
                selValid = S1_VALID;
                selLast  = S1_LAST;
                selData  = S1_DATA;
                selCh    = 1'b1;
            end
            default: begin
                selValid = 1'b0;
            end
        endcase
    end

    assign S0_READY = (state_q == GRANT0) && slotFree && !RESET;
    assign S1_READY = (state_q == GRANT1) && slotFree && !RESET;
    assign accept   = (S0_READY && S0_VALID) || (S1_READY && S1_VALID);

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] LAST_ALLOWED_IDX = 16'(MAX_FRAME_LEN - 1);

    logic [15:0] beatCnt_q, beatCnt_d;

    // A frame reaching its length limit without LAST is cut here and closed like a normal LAST.
    assign forceEnd = accept && !selLast && (beatCnt_q == LAST_ALLOWED_IDX);

    always_comb begin
        beatCnt_d = beatCnt_q;
        if (accept) begin
            if (selLast || forceEnd) begin
                beatCnt_d = 16'd0;
            end else begin
                beatCnt_d = beatCnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            beatCnt_q <= 16'd0;
        end else begin
            beatCnt_q <= beatCnt_d;
        end
    end
`else
    assign forceEnd = 1'b0;
`endif

    assign frameEnd = accept && (selLast || forceEnd);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Arbitration happens only from IDLE, so a granted frame is locked until it ends.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (S0_VALID && S1_VALID) begin
                    if (lastGrant_q) begin
                        state_d     = GRANT0;
                        lastGrant_d = 1'b0;
                    end else begin
                        state_d     = GRANT1;
                        lastGrant_d = 1'b1;
                    end
                end else if (S0_VALID) begin
                    state_d     = GRANT0;
                    lastGrant_d = 1'b0;
                end else if (S1_VALID) begin
                    state_d     = GRANT1;
                    lastGrant_d = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (frameEnd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mValid_d     = mValid_q;
        mData_d      = mData_q;
        mLast_d      = mLast_q;
        mCh_d        = mCh_q;
        timeoutErr_d = 1'b0;
        if (accept) begin
            mValid_d     = 1'b1;
            mData_d      = selData;
            mLast_d      = selLast || forceEnd;
            mCh_d        = selCh;
            timeoutErr_d = forceEnd;
        end else if (M_READY) begin
            mValid_d = 1'b0;
            mLast_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mValid_q     <= 1'b0;
            mData_q      <= '1;
            mLast_q      <= 1'b0;
            mCh_q        <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            mValid_q     <= mValid_d;
            mData_q      <= mData_d;
            mLast_q      <= mLast_d;
            mCh_q        <= mCh_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign M_VALID     = mValid_q;
    assign M_DATA      = mData_q;
    assign M_LAST      = mLast_q;
    assign M_CH        = mCh_q;
    assign TIMEOUT_ERR = timeoutErr_q;

endmodule

// File: tb/tb_dual_frame_arbiter.sv
// Randomized bench for dual_frame_arbiter against a frame-level arbitration model.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog (MAX_FRAME_LEN=8).
module tb_dual_frame_arbiter;

    localparam int DW     = 32;
    localparam int MAXLEN = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          S0_VALID, S0_READY, S0_LAST;
    logic [DW-1:0] S0_DATA;
    logic          S1_VALID, S1_READY, S1_LAST;
    logic [DW-1:0] S1_DATA;
    logic          M_VALID, M_READY, M_LAST, M_CH;
    logic [DW-1:0] M_DATA;
    logic          TIMEOUT_ERR;

    always #5 CLK = ~CLK;

    dual_frame_arbiter #(
        .DATA_WIDTH   (DW),
        .MAX_FRAME_LEN(MAXLEN)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .S0_VALID   (S0_VALID),
        .S0_READY   (S0_READY),
        .S0_DATA    (S0_DATA),
        .S0_LAST    (S0_LAST),
        .S1_VALID   (S1_VALID),
        .S1_READY   (S1_READY),
        .S1_DATA    (S1_DATA),
        .S1_LAST    (S1_LAST),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_DATA     (M_DATA),
        .M_LAST     (M_LAST),
        .M_CH       (M_CH),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    int checksDone   = 0;
    int checksPassed = 0;

    // Reference model: who owns the output, who won last, beats in frame, and the one-beat output slot.
    int            owner      = -1;
    int            prevWinner = 1;
    int            frameCnt   = 0;
    logic          sV         = 1'b0;
    logic          sLast      = 1'b0;
    logic          sCh        = 1'b0;
    logic [DW-1:0] sData      = '1;
    logic          expErr     = 1'b0;
    bit            resetView  = 1'b1;
    bit            timeoutOn;

    // Per-channel frame generators: pending beat data, beat index and frame length.
    logic [DW-1:0] gData [2];
    int            gIdx  [2];
    int            gLen  [2];
    logic          vIn   [2];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checksDone++;
        if (got === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pickLen(input int phase);
        if (phase == 0) return 4;
        if (phase == 1) return 3;
        return $urandom_range(1, 10);
    endfunction

    function automatic logic [DW-1:0] pickData(input int phase, input int idx);
        logic [DW-1:0] d;
        if (phase == 1) d = DW'(32'h11 * (idx + 1));
        else            d = DW'($urandom);
        return d;
    endfunction

    task automatic restartGenerators(input int phase);
        for (int c = 0; c < 2; c++) begin
            gIdx[c]  = 0;
            gLen[c]  = pickLen(phase);
            gData[c] = pickData(phase, 0);
        end
    endtask

    task automatic applyStimulus(input int phase, input bit doReset);
        int vPct, rPct;
        vPct = (phase == 0) ? 100 : (phase == 1 ? 80 : 75);
        rPct = (phase == 0) ? 100 : (phase == 1 ? 60 : 70);
        vIn[0] = (phase != 1) && ($urandom_range(0, 99) < vPct);
        vIn[1] = ($urandom_range(0, 99) < vPct);
        RESET    = doReset || (phase == 2 && $urandom_range(0, 299) == 0);
        S0_VALID = vIn[0];
        S0_DATA  = gData[0];
        S0_LAST  = (gIdx[0] == gLen[0] - 1);
        S1_VALID = vIn[1];
        S1_DATA  = gData[1];
        S1_LAST  = (gIdx[1] == gLen[1] - 1);
        M_READY  = ($urandom_range(0, 99) < rPct);
    endtask

    function automatic logic expReady(input int c);
        return !RESET && (owner == c) && (!sV || M_READY);
    endfunction

    task automatic checkStep();
        checkOutput("S0_READY", 64'(S0_READY), 64'(expReady(0)));
        checkOutput("S1_READY", 64'(S1_READY), 64'(expReady(1)));
        checkOutput("M_VALID", 64'(M_VALID), 64'(sV));
        checkOutput("TIMEOUT_ERR", 64'(TIMEOUT_ERR), 64'(expErr));
        if (sV || resetView) begin
            checkOutput("M_DATA", 64'(M_DATA), 64'(sData));
            checkOutput("M_CH", 64'(M_CH), 64'(sCh));
            checkOutput("M_LAST", 64'(M_LAST), 64'(sLast));
        end
    endtask

    task automatic modelStep(input int phase);
        int  old;
        bit  acc, forced, isLast;
        int  c;
        old = owner;
        if (RESET) begin
            owner = -1; prevWinner = 1; frameCnt = 0;
            sV = 1'b0; sLast = 1'b0; sCh = 1'b0; sData = '1; expErr = 1'b0;
            resetView = 1'b1;
            return;
        end
        c   = (old < 0) ? 0 : old;
        acc = (old >= 0) && expReady(old) && vIn[c];
        if (acc) begin
            isLast    = (gIdx[c] == gLen[c] - 1);
            forced    = timeoutOn && !isLast && (frameCnt + 1 == MAXLEN);
            sV        = 1'b1;
            sData     = gData[c];
            sLast     = isLast || forced;
            sCh       = (c == 1);
            expErr    = forced;
            resetView = 1'b0;
            if (isLast || forced) begin
                owner    = -1;
                frameCnt = 0;
            end else begin
                frameCnt++;
            end
            if (isLast) begin
                gIdx[c] = 0;
                gLen[c] = pickLen(phase);
            end else begin
                gIdx[c]++;
            end
            gData[c] = pickData(phase, gIdx[c]);
        end else begin
            expErr = 1'b0;
            if (M_READY) begin
                sV    = 1'b0;
                sLast = 1'b0;
            end
        end
        if (old < 0) begin
            if (vIn[0] && vIn[1]) owner = (prevWinner == 1) ? 0 : 1;
            else if (vIn[0])      owner = 0;
            else if (vIn[1])      owner = 1;
            if (owner >= 0) prevWinner = owner;
        end
    endtask

    task automatic runCycle(input int phase, input bit doReset);
        @(negedge CLK);
        applyStimulus(phase, doReset);
        #1;
        checkStep();
        modelStep(phase);
    endtask

    initial begin
`ifdef ARB_TIMEOUT_EN
        timeoutOn = 1'b1;
`else
        timeoutOn = 1'b0;
`endif
        RESET    = 1'b1;
        S0_VALID = 1'b0; S0_DATA = '0; S0_LAST = 1'b0;
        S1_VALID = 1'b0; S1_DATA = '0; S1_LAST = 1'b0;
        M_READY  = 1'b0;
        for (int c = 0; c < 2; c++) vIn[c] = 1'b0;

        for (int p = 0; p < 3; p++) begin
            restartGenerators(p);
            runCycle(p, 1'b1);
            runCycle(p, 1'b1);
            for (int n = 0; n < (p == 2 ? 4000 : 60); n++) begin
                runCycle(p, 1'b0);
            end
        end

        $display("[TB] %0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
